// File: rtl/hms_clock.sv
`default_nettype none
// ============================================================================
// hms_clock : hh:mm:ss time-of-day core with run/set FSM, 12/24-hour format,
//             field blink and colon. Optional alarm enabled by macro ALARM_EN.
// Revision  : 1.0
// ============================================================================
module hms_clock #(
   parameter int CLK_HZ = 50000000,
   parameter bit H24    = 1'b1
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       clr,
   input  logic       mode_p,
   input  logic       next_p,
   input  logic       inc_p,
   output logic [1:0] hr10,
   output logic [3:0] hr1,
   output logic [2:0] min10,
   output logic [3:0] min1,
   output logic [2:0] sec10,
   output logic [3:0] sec1,
   output logic       pm,
   output logic [2:0] blink,
   output logic       colon,
   output logic       setting,
   output logic       alarm
);

   localparam int            HALF   = CLK_HZ / 2;
   localparam int            PW     = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [PW-1:0] TERM   = PW'(HALF - 1);
   // Hours are held as {pm, hr10, hr1}
   localparam logic [6:0]    RST_HR = H24 ? 7'h00 : 7'h12;

`ifdef ALARM_EN
   typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_S, SET_AH, SET_AM} state_t;
`else
   typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} state_t;
`endif

   state_t        state, state_n;
   logic [PW-1:0] cnt;
   logic          phase;
   logic          half_tick, sec_tick, exit_run;
   logic [6:0]    sec, sec_n, min, min_n, hr, hr_n;
   logic [6:0]    hr_disp, min_disp;

   function automatic logic [6:0] inc60(input logic [6:0] v);
      logic [6:0] r;
      if (v[3:0] == 4'd9)
         r = (v[6:4] == 3'd5) ? 7'h00 : {v[6:4] + 3'd1, 4'd0};
      else
         r = {v[6:4], v[3:0] + 4'd1};
      return r;
   endfunction

   function automatic logic [6:0] next_hour(input logic [6:0] h);
      logic [6:0] r;
      r = {h[6], h[5:4], h[3:0] + 4'd1};
      if (H24) begin
         if (h[5:0] == 6'h23)
            r = 7'h00;
         else if (h[3:0] == 4'd9)
            r = {1'b0, h[5:4] + 2'd1, 4'd0};
      end else begin
         // 12h order is 12,01..11; the meridiem flips entering 12
         if (h[5:0] == 6'h12)
            r = {h[6], 6'h01};
         else if (h[5:0] == 6'h11)
            r = {~h[6], 6'h12};
         else if (h[3:0] == 4'd9)
            r = {h[6], 6'h10};
      end
      return r;
   endfunction

   assign half_tick = (cnt == TERM);
   assign sec_tick  = half_tick && phase;
   assign exit_run  = (state != RUN) && mode_p;
   assign colon     = ~phase;
   assign setting   = (state != RUN);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (clr || exit_run) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (half_tick) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt   <= cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= RUN;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      blink   = 3'b000;
      case (state)
         RUN: if (mode_p) state_n = SET_H;
         SET_H: begin
            blink = {phase, 2'b00};
            if (mode_p)      state_n = RUN;
            else if (next_p) state_n = SET_M;
         end
         SET_M: begin
            blink = {1'b0, phase, 1'b0};
            if (mode_p)      state_n = RUN;
            else if (next_p) state_n = SET_S;
         end
         SET_S: begin
            blink = {2'b00, phase};
            if (mode_p)      state_n = RUN;
`ifdef ALARM_EN
            else if (next_p) state_n = SET_AH;
`else
            else if (next_p) state_n = SET_H;
`endif
         end
`ifdef ALARM_EN
         SET_AH: begin
            blink = {phase, 2'b00};
            if (mode_p)      state_n = RUN;
            else if (next_p) state_n = SET_AM;
         end
         SET_AM: begin
            blink = {1'b0, phase, 1'b0};
            if (mode_p)      state_n = RUN;
            else if (next_p) state_n = SET_H;
         end
`endif
         default: state_n = RUN;
      endcase
   end

   always_comb begin
      sec_n = sec;
      min_n = min;
      hr_n  = hr;
      if (clr) begin
         sec_n = 7'h00;
         min_n = 7'h00;
         hr_n  = RST_HR;
      end else if (state == RUN) begin
         if (sec_tick) begin
            sec_n = inc60(sec);
            if (sec == 7'h59) begin
               min_n = inc60(min);
               if (min == 7'h59) hr_n = next_hour(hr);
            end
         end
      end else if (inc_p) begin
         // Field edits wrap in place and never carry
         case (state)
            SET_H:   hr_n  = next_hour(hr);
            SET_M:   min_n = inc60(min);
            SET_S:   sec_n = inc60(sec);
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         sec <= 7'h00;
         min <= 7'h00;
         hr  <= RST_HR;
      end else begin
         sec <= sec_n;
         min <= min_n;
         hr  <= hr_n;
      end
   end

`ifdef ALARM_EN
   logic [6:0] a_hr, a_hr_n, a_min, a_min_n;
   logic [5:0] a_cnt;
   logic       alarm_r, any_pulse, hit, alarm_view;

   assign any_pulse  = clr || mode_p || next_p || inc_p;
   assign hit        = (state == RUN) && sec_tick && !clr && (sec_n == 7'h00) &&
                       (hr_n == a_hr) && (min_n == a_min);
   assign alarm_view = (state == SET_AH) || (state == SET_AM);

   always_comb begin
      a_hr_n  = a_hr;
      a_min_n = a_min;
      if (!clr && inc_p) begin
         if (state == SET_AH)      a_hr_n  = next_hour(a_hr);
         else if (state == SET_AM) a_min_n = inc60(a_min);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         a_hr    <= RST_HR;
         a_min   <= 7'h00;
         a_cnt   <= 6'd0;
         alarm_r <= 1'b0;
      end else begin
         a_hr  <= a_hr_n;
         a_min <= a_min_n;
         if (any_pulse) begin
            alarm_r <= 1'b0;
            a_cnt   <= 6'd0;
         end else if (hit) begin
            alarm_r <= 1'b1;
            a_cnt   <= 6'd0;
         end else if (alarm_r && sec_tick) begin
            if (a_cnt == 6'd59) alarm_r <= 1'b0;
            else                a_cnt   <= a_cnt + 6'd1;
         end
      end
   end

   assign alarm    = alarm_r;
   assign hr_disp  = alarm_view ? a_hr  : hr;
   assign min_disp = alarm_view ? a_min : min;
`else
   assign alarm    = 1'b0;
   assign hr_disp  = hr;
   assign min_disp = min;
`endif

   assign pm    = hr_disp[6];
   assign hr10  = hr_disp[5:4];
   assign hr1   = hr_disp[3:0];
   assign min10 = min_disp[6:4];
   assign min1  = min_disp[3:0];
   assign sec10 = sec[6:4];
   assign sec1  = sec[3:0];

endmodule
`default_nettype wire

// File: tb/tb_hms_clock.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_hms_clock : directed bench for hms_clock, one 24h and one 12h instance
//                sharing stimulus. Covers ALARM_EN when that macro is defined.
// Revision     : 1.0
// ============================================================================
module tb_hms_clock;
   localparam int CLK_HZ = 4;
   localparam int P_CLR  = 0;
   localparam int P_MODE = 1;
   localparam int P_NEXT = 2;
   localparam int P_INC  = 3;

   logic CLK = 1'b0;
   logic nRST = 1'b1;
   logic clr = 1'b0, mode_p = 1'b0, next_p = 1'b0, inc_p = 1'b0;

   logic [1:0] hr10_a, hr10_b;
   logic [3:0] hr1_a, hr1_b, min1_a, min1_b, sec1_a, sec1_b;
   logic [2:0] min10_a, min10_b, sec10_a, sec10_b, blink_a, blink_b;
   logic       pm_a, pm_b, colon_a, colon_b, setting_a, setting_b, alarm_a, alarm_b;
   logic [23:0] t24;
   logic [27:0] t12;

   int tests = 0;
   int fails = 0;

   hms_clock #(.CLK_HZ(CLK_HZ), .H24(1'b1)) dut24 (
      .CLK(CLK), .nRST(nRST), .clr(clr), .mode_p(mode_p), .next_p(next_p), .inc_p(inc_p),
      .hr10(hr10_a), .hr1(hr1_a), .min10(min10_a), .min1(min1_a), .sec10(sec10_a),
      .sec1(sec1_a), .pm(pm_a), .blink(blink_a), .colon(colon_a), .setting(setting_a),
      .alarm(alarm_a));

   hms_clock #(.CLK_HZ(CLK_HZ), .H24(1'b0)) dut12 (
      .CLK(CLK), .nRST(nRST), .clr(clr), .mode_p(mode_p), .next_p(next_p), .inc_p(inc_p),
      .hr10(hr10_b), .hr1(hr1_b), .min10(min10_b), .min1(min1_b), .sec10(sec10_b),
      .sec1(sec1_b), .pm(pm_b), .blink(blink_b), .colon(colon_b), .setting(setting_b),
      .alarm(alarm_b));

   assign t24 = {2'b00, hr10_a, hr1_a, 1'b0, min10_a, min1_a, 1'b0, sec10_a, sec1_a};
   assign t12 = {3'b000, pm_b, 2'b00, hr10_b, hr1_b, 1'b0, min10_b, min1_b,
                 1'b0, sec10_b, sec1_b};

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic press(input int which, input int n);
      for (int i = 0; i < n; i++) begin
         case (which)
            P_CLR:   clr    = 1'b1;
            P_MODE:  mode_p = 1'b1;
            P_NEXT:  next_p = 1'b1;
            default: inc_p  = 1'b1;
         endcase
         @(posedge CLK);
         #1;
         clr = 1'b0; mode_p = 1'b0; next_p = 1'b0; inc_p = 1'b0;
      end
   endtask

   task automatic test_reset;
      #1 nRST = 1'b0;
      @(negedge CLK);
      tests++; if (t24 !== 24'h000000) begin fails++; $display("FAIL reset_time24: got %h expected 000000", t24); end
      tests++; if (t12 !== 28'h0120000) begin fails++; $display("FAIL reset_time12: got %h expected 0120000", t12); end
      tests++; if ({colon_a, blink_a, setting_a, alarm_a, pm_a} !== 7'b1000000) begin
         fails++; $display("FAIL reset_flags: got %b expected 1000000", {colon_a, blink_a, setting_a, alarm_a, pm_a}); end
      @(posedge CLK);
      #1 nRST = 1'b1;
   endtask

   task automatic test_run_minute;
      tick(1);
      tests++; if (colon_a !== 1'b1) begin fails++; $display("FAIL colon_c1: got %b expected 1", colon_a); end
      tick(1);
      tests++; if (colon_a !== 1'b0) begin fails++; $display("FAIL colon_c2: got %b expected 0", colon_a); end
      tick(2);
      tests++; if ({colon_a, t24} !== {1'b1, 24'h000001}) begin
         fails++; $display("FAIL first_second: got %b/%h expected 1/000001", colon_a, t24); end
      tick(236);
      tests++; if (t24 !== 24'h000100) begin fails++; $display("FAIL run_minute24: got %h expected 000100", t24); end
      tests++; if (t12 !== 28'h0120100) begin fails++; $display("FAIL run_minute12: got %h expected 0120100", t12); end
      tests++; if (alarm_a !== 1'b0) begin fails++; $display("FAIL alarm_idle: got %b expected 0", alarm_a); end
   endtask

   task automatic test_rollover24;
      press(P_CLR, 1);
      press(P_MODE, 1);
      press(P_INC, 23);
      press(P_NEXT, 1);
      press(P_INC, 59);
      press(P_NEXT, 1);
      press(P_INC, 58);
      tests++; if ({setting_a, t24} !== {1'b1, 24'h235958}) begin
         fails++; $display("FAIL preload24: got %b/%h expected 1/235958", setting_a, t24); end
      press(P_MODE, 1);
      tick(3);
      tests++; if ({setting_a, t24} !== {1'b0, 24'h235958}) begin
         fails++; $display("FAIL exit_hold24: got %b/%h expected 0/235958", setting_a, t24); end
      tick(1);
      tests++; if (t24 !== 24'h235959) begin fails++; $display("FAIL tick_235959: got %h expected 235959", t24); end
      tick(4);
      tests++; if (t24 !== 24'h000000) begin fails++; $display("FAIL wrap_day24: got %h expected 000000", t24); end
      tests++; if (t12 !== 28'h0120000) begin fails++; $display("FAIL wrap_pm_to_am: got %h expected 0120000", t12); end
   endtask

   task automatic test_12h;
      press(P_CLR, 1);
      press(P_MODE, 1);
      press(P_INC, 11);
      press(P_NEXT, 1);
      press(P_INC, 59);
      press(P_NEXT, 1);
      press(P_INC, 59);
      tests++; if (t12 !== 28'h0115959) begin fails++; $display("FAIL preload12: got %h expected 0115959", t12); end
      press(P_MODE, 1);
      tick(4);
      tests++; if (t12 !== 28'h1120000) begin fails++; $display("FAIL noon12: got %h expected 1120000", t12); end
      press(P_MODE, 1);
      press(P_NEXT, 1);
      press(P_INC, 59);
      press(P_NEXT, 1);
      press(P_INC, 59);
      tests++; if (t12 !== 28'h1125959) begin fails++; $display("FAIL preload12b: got %h expected 1125959", t12); end
      press(P_MODE, 1);
      tick(4);
      tests++; if (t12 !== 28'h1010000) begin fails++; $display("FAIL one_pm12: got %h expected 1010000", t12); end
   endtask

   task automatic test_set_mode;
      int on_cnt, off_cnt, bad_cnt;
      on_cnt = 0; off_cnt = 0; bad_cnt = 0;
      press(P_CLR, 1);
      press(P_MODE, 1);
      tests++; if (setting_a !== 1'b1) begin fails++; $display("FAIL enter_set: got %b expected 1", setting_a); end
      press(P_NEXT, 1);
      press(P_INC, 61);
      tests++; if (t24 !== 24'h000100) begin fails++; $display("FAIL min_wrap61: got %h expected 000100", t24); end
      for (int i = 0; i < 4; i++) begin
         tick(1);
         if (blink_a === 3'b010)      on_cnt++;
         else if (blink_a === 3'b000) off_cnt++;
         else                         bad_cnt++;
      end
      tests++; if (on_cnt == 0 || off_cnt == 0 || bad_cnt != 0) begin
         fails++; $display("FAIL blink_min: on=%0d off=%0d other=%0d expected on>0 off>0 other=0", on_cnt, off_cnt, bad_cnt); end
      press(P_MODE, 1);
      press(P_INC, 1);
      press(P_NEXT, 1);
      tests++; if ({setting_a, blink_a, t24} !== {1'b0, 3'b000, 24'h000100}) begin
         fails++; $display("FAIL run_ignores: got %b/%b/%h expected 0/000/000100", setting_a, blink_a, t24); end
      tick(1);
      tests++; if (t24 !== 24'h000100) begin fails++; $display("FAIL full_second_hold: got %h expected 000100", t24); end
      tick(1);
      tests++; if (t24 !== 24'h000101) begin fails++; $display("FAIL full_second_tick: got %h expected 000101", t24); end
   endtask

   task automatic test_clr_priority;
      press(P_CLR, 1);
      press(P_MODE, 1);
      press(P_NEXT, 2);
      press(P_INC, 45);
      tests++; if (t24 !== 24'h000045) begin fails++; $display("FAIL preload45: got %h expected 000045", t24); end
      clr = 1'b1; inc_p = 1'b1;
      @(posedge CLK);
      #1 clr = 1'b0; inc_p = 1'b0;
      tests++; if ({setting_a, t24} !== {1'b1, 24'h000000}) begin
         fails++; $display("FAIL clr_over_inc: got %b/%h expected 1/000000", setting_a, t24); end
      press(P_INC, 1);
      tests++; if (t24 !== 24'h000001) begin fails++; $display("FAIL still_set_s: got %h expected 000001", t24); end
      press(P_MODE, 1);
   endtask

`ifdef ALARM_EN
   task automatic test_alarm;
      press(P_CLR, 1);
      press(P_MODE, 1);
      press(P_NEXT, 4);
      press(P_INC, 2);
      tests++; if (t24 !== 24'h000200) begin fails++; $display("FAIL alarm_view: got %h expected 000200", t24); end
      press(P_NEXT, 2);
      press(P_INC, 1);
      press(P_NEXT, 1);
      press(P_INC, 59);
      tests++; if (t24 !== 24'h000159) begin fails++; $display("FAIL alarm_preload: got %h expected 000159", t24); end
      press(P_MODE, 1);
      tick(3);
      tests++; if (alarm_a !== 1'b0) begin fails++; $display("FAIL alarm_early: got %b expected 0", alarm_a); end
      tick(1);
      tests++; if ({alarm_a, t24} !== {1'b1, 24'h000200}) begin
         fails++; $display("FAIL alarm_rise: got %b/%h expected 1/000200", alarm_a, t24); end
      press(P_INC, 1);
      tests++; if (alarm_a !== 1'b0) begin fails++; $display("FAIL alarm_cancel: got %b expected 0", alarm_a); end
      press(P_MODE, 1);
      press(P_NEXT, 1);
      press(P_INC, 59);
      press(P_NEXT, 1);
      press(P_INC, 59);
      press(P_MODE, 1);
      tick(4);
      tests++; if ({alarm_a, t24} !== {1'b1, 24'h000200}) begin
         fails++; $display("FAIL alarm_rise2: got %b/%h expected 1/000200", alarm_a, t24); end
      tick(236);
      tests++; if ({alarm_a, t24} !== {1'b1, 24'h000259}) begin
         fails++; $display("FAIL alarm_hold: got %b/%h expected 1/000259", alarm_a, t24); end
      tick(4);
      tests++; if ({alarm_a, t24} !== {1'b0, 24'h000300}) begin
         fails++; $display("FAIL alarm_timeout: got %b/%h expected 0/000300", alarm_a, t24); end
   endtask
`endif

   initial begin
      test_reset();
      test_run_minute();
      test_rollover24();
      test_12h();
      test_set_mode();
      test_clr_priority();
`ifdef ALARM_EN
      test_alarm();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hms_clock.md
Name: hms_clock

Overview:
- Parametrised successor to the minutes:seconds counter: a full hours:minutes:seconds time-of-day core with a run/set state machine, selectable 12/24-hour format and field-blink indication.
- Sits between the button conditioner, which supplies debounced one-cycle pulses, and the per-digit 7-segment decoders.
- All digit outputs are registered BCD.

Parameters:
- CLK_HZ, 50000000, input clock frequency; must be even and >= 2.
- H24, 1, 1 = 24-hour (00-23); 0 = 12-hour (12,01..11 with pm flag).

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- clr  in  1  one-cycle pulse: clear time
- mode_p  in  1  one-cycle pulse: enter/exit set mode
- next_p  in  1  one-cycle pulse: select next field in set mode
- inc_p  in  1  one-cycle pulse: increment selected field
- hr10  out  2  hours tens BCD
- hr1  out  4  hours units BCD
- min10  out  3  minutes tens
- min1  out  4  minutes units
- sec10  out  3  seconds tens
- sec1  out  4  seconds units
- pm  out  1  PM flag; always 0 when H24=1
- blink  out  3  {hr,min,sec} blank request for the selected field
- colon  out  1  1 during first half of each second
- setting  out  1  1 when not in RUN
- alarm  out  1  alarm active; tied 0 without ALARM_EN

Behaviour:
- Reset (nRST low, asynchronous):
  - time = 00:00:00 when H24=1; 12:00:00 with pm=0 when H24=0.
  - state RUN, prescaler 0, half-phase 0.
  - colon=1, blink=0, setting=0, alarm=0.
- Prescaler:
  - Counts 0..CLK_HZ/2-1 and produces a half-tick at terminal count.
  - The half-phase bit toggles on each half-tick.
  - The second-tick is a half-tick with half-phase=1. colon = ~half-phase.
  - The prescaler runs in all states.
- States: RUN, SET_H, SET_M, SET_S (plus SET_AH, SET_AM with ALARM_EN).
  - RUN: mode_p -> SET_H.
  - SET_x: next_p -> next field (H->M->S->H); mode_p -> RUN.
  - On exit to RUN, prescaler and half-phase are cleared so the first second is full length.
  - mode_p wins over next_p in the same cycle.
- RUN: each second-tick advances seconds.
  - 59 -> 00 carries to minutes; minutes 59 -> 00 carries to hours.
  - 24h: 23:59:59 -> 00:00:00.
  - 12h: 11:59:59 -> 12:00:00 with pm toggled; 12:59:59 -> 01:00:00 with pm unchanged.
  - inc_p and next_p are ignored in RUN.
- SET_x: time frozen; second-ticks are ignored.
  - inc_p increments only the selected field, wraps with no carry:
    - seconds 59 -> 00, minutes 59 -> 00.
    - hours follow the rollover sequence, including the pm toggle at 11 -> 12 in 12h mode.
  - blink bit of the selected field = half-phase; other bits 0. blink=0 in RUN.
- clr: loads the reset time value and clears the prescaler.
  - State is unchanged.
  - clr has priority over the tick and over inc_p in the same cycle.
- Latency: every update is visible on the outputs on the cycle after the tick or pulse.
- Outputs are always valid BCD; no illegal digit code is ever reachable.

Optional Feature:
- Macro ALARM_EN.
- When defined:
  - Alarm hour and minute registers are added; reset value 00 (24h) or 12 AM (12h).
  - next_p cycles H->M->S->AH->AM->H.
  - In SET_AH and SET_AM, the hour and minute outputs show the alarm registers and inc_p edits them using the same wrap rules.
  - alarm is set on the RUN second-tick that produces hh:mm:00 equal to the alarm value.
  - alarm is cleared after 60 second-ticks, or on any clr, mode_p, next_p or inc_p pulse.
  - alarm never asserts from reset or from clr alone.
- When undefined: alarm is constant 0; no alarm states or registers exist.

Test Plan:
- CLK_HZ=4, H24=1: release reset, run 240 cycles -> 00:01:00 displayed; colon toggles every 2 cycles.
- H24=1: force 23:59:58 via set mode, exit, run 2 s -> 23:59:59 then 00:00:00.
- H24=0: preload 11:59:59 pm=0, 1 s -> 12:00:00 pm=1; preload 12:59:59, 1 s -> 01:00:00 pm=1.
- Set mode:
  - mode_p, next_p, inc_p x61 -> minutes advance by 61 mod 60 = 01; hours and seconds unchanged.
  - blink=3'b010 pulsing.
  - mode_p -> setting=0; the next second-tick arrives after exactly CLK_HZ cycles.
- clr and inc_p in the same cycle in SET_S at 00:00:45 -> 00:00:00, state remains SET_S.
- ALARM_EN:
  - alarm set to 00:02, run from 00:01:59 -> alarm rises at 00:02:00.
  - inc_p pulse -> alarm falls the next cycle.
  - Without the pulse, alarm falls at 00:03:00.
